// File: rtl/usb_hid_key_events.sv
// Keyboard report differ: one make/break event per changed modifier bit or key slot, queued in an event FIFO.
// First event reaches ev_valid two cycles after the pending report is taken; a slot that must emit into a full FIFO holds, never drops.

module fifo #(
  parameter int W     = 9,
  parameter int DEPTH = 16
) (
  input  logic                   usbclk,
  input  logic                   usbrst,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [W-1:0]           in_dat,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [W-1:0]           out_dat,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = DEPTH[AW:0];

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  assign out_vld = (count != '0);
  assign pop     = out_vld & out_rdy;
  // a pop in the same cycle frees the slot, so push and pop at full both proceed
  assign in_rdy  = (count != FULL) | out_rdy;
  assign push    = in_vld & in_rdy;
  assign out_dat = out_vld ? mem[rd_ptr] : '0;

  always_ff @(posedge usbclk) begin
    if (push) mem[wr_ptr] <= in_dat;
  end

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module usb_hid_key_events #(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                        usbclk,
  input  logic                        usbrst,
  input  logic [1:0]                  typ,
  input  logic                        report,
  input  logic [7:0]                  key_modifiers,
  input  logic [7:0]                  key1,
  input  logic [7:0]                  key2,
  input  logic [7:0]                  key3,
  input  logic [7:0]                  key4,
  output logic                        ev_valid,
  input  logic                        ev_ready,
  output logic                        ev_press,
  output logic [7:0]                  ev_code,
  output logic [$clog2(FIFO_DEPTH):0] ev_count,
  output logic                        ev_lost,
  output logic                        busy
);
  typedef logic [3:0][7:0] kset_t;
  typedef struct packed {
    logic [7:0] mods;
    kset_t      keys;
  } kstate_t;
  typedef struct packed {
    logic       press;
    logic [7:0] code;
  } ev_t;
  typedef enum logic [1:0] {IDLE, MOD, REL, PRS} state_t;

  state_t  state, state_nx;
  logic [2:0] slot, slot_nx;
  logic [1:0] typ_q;
  kstate_t pend, cur, prev, cap_dat;
  logic    pend_full;
  logic    rollover, cap, take, scan_done;
  logic    emit, fifo_rdy;
  ev_t     emit_dat, head;

  // src[i] emits if non-empty, missing from other, and first of its value within src
  function automatic logic slot_emits(input kset_t src, input kset_t other, input logic [1:0] i);
    logic [7:0] code;
    logic       keep;
    code = src[i];
    keep = (code != 8'h00);
    for (int j = 0; j < 4; j++) begin
      if (other[j] == code) keep = 1'b0;
      if ((j < int'(i)) && (src[j] == code)) keep = 1'b0;
    end
    return keep;
  endfunction

  assign rollover = (key1 == 8'h01) | (key2 == 8'h01) | (key3 == 8'h01) | (key4 == 8'h01);
  assign cap      = (report & (typ == 2'd1) & ~rollover) | ((typ_q == 2'd1) & (typ != 2'd1));
  assign cap_dat  = (typ == 2'd1) ? kstate_t'{mods: key_modifiers, keys: {key4, key3, key2, key1}}
                                  : kstate_t'('0);
  assign take     = (state == IDLE) & pend_full;
  assign busy     = (state != IDLE) | pend_full;

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      state <= IDLE;
      slot  <= '0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    slot_nx   = slot;
    emit      = 1'b0;
    emit_dat  = '0;
    scan_done = 1'b0;
    case (state)
      IDLE: begin
        if (pend_full) begin
          state_nx = MOD;
          slot_nx  = '0;
        end
      end
      MOD: begin
        emit     = (prev.mods[slot] != cur.mods[slot]);
        emit_dat = '{press: cur.mods[slot], code: 8'hE0 + {5'd0, slot}};
        if (!emit || fifo_rdy) begin
          slot_nx = slot + 3'd1;
          if (slot == 3'd7) state_nx = REL;
        end
      end
      REL: begin
        emit     = slot_emits(prev.keys, cur.keys, slot[1:0]);
        emit_dat = '{press: 1'b0, code: prev.keys[slot[1:0]]};
        if (!emit || fifo_rdy) begin
          slot_nx = slot + 3'd1;
          if (slot == 3'd3) begin
            state_nx = PRS;
            slot_nx  = '0;
          end
        end
      end
      PRS: begin
        emit     = slot_emits(cur.keys, prev.keys, slot[1:0]);
        emit_dat = '{press: 1'b1, code: cur.keys[slot[1:0]]};
        if (!emit || fifo_rdy) begin
          slot_nx = slot + 3'd1;
          if (slot == 3'd3) begin
            state_nx  = IDLE;
            slot_nx   = '0;
            scan_done = 1'b1;
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge usbclk or posedge usbrst) begin
    if (usbrst) begin
      typ_q     <= '0;
      pend      <= '0;
      pend_full <= 1'b0;
      cur       <= '0;
      prev      <= '0;
      ev_lost   <= 1'b0;
    end else begin
      typ_q <= typ;
      if (take)      cur  <= pend;
      if (scan_done) prev <= cur;
      // a capture on the same edge the FSM takes pending replaces nothing unscanned
      if (cap) begin
        pend      <= cap_dat;
        pend_full <= 1'b1;
        if (pend_full && !take) ev_lost <= 1'b1;
      end else if (take) begin
        pend_full <= 1'b0;
      end
    end
  end

  fifo #(
    .W     ($bits(ev_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .usbclk  (usbclk),
    .usbrst  (usbrst),
    .in_vld  (emit),
    .in_rdy  (fifo_rdy),
    .in_dat  (emit_dat),
    .out_vld (ev_valid),
    .out_rdy (ev_ready),
    .out_dat (head),
    .count   (ev_count)
  );

  assign ev_press = head.press;
  assign ev_code  = head.code;
endmodule
